// File: rtl/cla_seq_arb.sv
// cla_seq_arb: two-requester round-robin arbiter and sequencer. It runs a W-bit add or subtract
// through one shared 4-bit carry-lookahead slice, one nibble per cycle with the LSB nibble first.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_i, aN_i, bN_i, subN_i   requester N operation request and operands (N = 0, 1)
//   gnt0_o, gnt1_o               one-cycle grant; operands are sampled at this edge
//   busy_o                       high from the cycle after a grant through the done cycle
//   done_o                       one-cycle pulse; result outputs are valid
//   owner_o                      requester index of the current or last result
//   sum_o, cout_o, ovf_o, zero_o result and flags, held until the next operation
module cla_seq_arb #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W      = 4 * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic         sub0_i,
  input  logic         req1_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  input  logic         sub1_i,
  output logic         gnt0_o,
  output logic         gnt1_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         owner_o,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         zero_o
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;      // already inverted for subtract
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;  // requester served last; the other wins a tie
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic            grant0, grant1, sel_sub;

  // Shared 4-bit carry-lookahead slice
  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_s;
  logic [4:0] nib_c;

  always_comb begin
    nib_a    = a_q[{idx_q, 2'b00} +: 4];
    nib_b    = b_q[{idx_q, 2'b00} +: 4];
    nib_g    = nib_a & nib_b;
    nib_p    = nib_a ^ nib_b;
    nib_c[0] = carry_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_s    = nib_p ^ nib_c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    owner_d = owner_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    sel_sub = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reset takes priority over a simultaneous request: no grant is shown.
        if (!rst_i) begin
          if (req0_i && (!req1_i || last_q)) begin
            grant0 = 1'b1;
          end else if (req1_i) begin
            grant1 = 1'b1;
          end
        end
        if (grant0 || grant1) begin
          sel_sub = grant1 ? sub1_i : sub0_i;
          a_d     = grant1 ? a1_i : a0_i;
          b_d     = grant1 ? b1_i : b0_i;
          if (sel_sub) begin
            b_d = ~b_d;
          end
          carry_d = sel_sub;
          idx_d   = '0;
          owner_d = grant1;
          last_d  = grant1;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_c[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = nib_c[4];
          ovf_d   = nib_c[3] ^ nib_c[4];
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign gnt0_o  = grant0;
  assign gnt1_o  = grant1;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);
  assign owner_o = owner_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_cla_seq_arb.sv
module tb_cla_seq_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, sub0, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, owner, cout, ovf, zero;
  logic [15:0] sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_seq_arb #(.NIBBLES(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req0_i (req0),
    .a0_i   (a0),
    .b0_i   (b0),
    .sub0_i (sub0),
    .req1_i (req1),
    .a1_i   (a1),
    .b1_i   (b1),
    .sub1_i (sub1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1),
    .busy_o (busy),
    .done_o (done),
    .owner_o(owner),
    .sum_o  (sum),
    .cout_o (cout),
    .ovf_o  (ovf),
    .zero_o (zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] xsum;
    logic        xcout;
    logic        xovf;
    logic        xzero;
  } vec_t;

  vec_t vecs[6];

  // Reference: plain W+1-bit arithmetic and the signed-overflow sign rule.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic [16:0] full;
    logic [15:0] bb;
    logic        ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    ov   = (a[15] == bb[15]) && (full[15] != a[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
    if (r == 0) begin
      req0 = 1'b1; a0 = a; b0 = b; sub0 = s;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; sub1 = s;
    end
  endtask

  // Wait (bounded) for done; returns the cycle count since the grant edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] xs, input logic xc, input logic xo, input logic xz);
    int cyc;
    set_req(r, a, b, s);
    #1;
    chk("grant_select", {30'd0, gnt1, gnt0}, (r == 0) ? 32'd1 : 32'd2);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    chk("done_low_in_run", {31'd0, done}, 32'd0);
    wait_done(cyc);
    chk("done_latency", cyc, 32'd5);
    chk("sum", {16'd0, sum}, {16'd0, xs});
    chk("cout", {31'd0, cout}, {31'd0, xc});
    chk("ovf", {31'd0, ovf}, {31'd0, xo});
    chk("zero", {31'd0, zero}, {31'd0, xz});
    chk("owner", {31'd0, owner}, r);
    tick();
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [17:0] m;
    int          cyc;
    int          ndone;
    int          gcyc[$];
    int          gwho[$];

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    chk("reset_ctrl", {28'd0, gnt0, gnt1, busy, done}, 32'd0);
    chk("reset_result", {13'd0, owner, cout, ovf, sum}, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    // rst and req together: rst wins
    req0 = 1'b1;
    #1;
    chk("rst_beats_req_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk("rst_beats_req_busy", {31'd0, busy}, 32'd0);
    req0 = 1'b0;
    rst  = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_op(i % 2, vecs[i].a, vecs[i].b, vecs[i].s,
            vecs[i].xsum, vecs[i].xcout, vecs[i].xovf, vecs[i].xzero);
    end

    // Randomized against the model
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      int          rr;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rr = int'($urandom_range(1, 0));
      m  = model(ra, rb, rs);
      do_op(rr, ra, rb, rs, m[15:0], m[16], m[17], m[15:0] == 16'd0);
    end

    // Contention from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 16'h1111, 16'h2222, 1'b0);
    set_req(1, 16'h9000, 16'h0001, 1'b1);
    for (int c = 0; c < 24; c++) begin
      #1;
      if (gnt0 || gnt1) begin
        gcyc.push_back(c);
        gwho.push_back(gnt1 ? 1 : 0);
      end
      if (done) begin
        m = (gwho.size() > 0 && gwho[gwho.size()-1] == 1) ? model(16'h9000, 16'h0001, 1'b1)
                                                          : model(16'h1111, 16'h2222, 1'b0);
        chk("contention_owner", {31'd0, owner},
            (gwho.size() > 0) ? gwho[gwho.size()-1] : 32'hDEAD);
        chk("contention_sum", {16'd0, sum}, {16'd0, m[15:0]});
        chk("contention_flags", {30'd0, cout, ovf}, {30'd0, m[16], m[17]});
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("contention_grant_count", gcyc.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gcyc.size()) begin
        chk("contention_grant_cycle", gcyc[k], 6 * k);
        chk("contention_grant_who", gwho[k], k % 2);
      end
    end
    wait_done(cyc);
    tick();

    // Reset during nibble index 2 of a requester-0 operation
    set_req(0, 16'hFFFF, 16'h0001, 1'b0);
    #1;
    chk("abort_grant", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {30'd0, busy, done}, 32'd0);
    chk("abort_result", {13'd0, owner, cout, ovf, sum}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 32'd0);
    set_req(0, 16'h0100, 16'h0200, 1'b0);
    set_req(1, 16'h0300, 16'h0400, 1'b0);
    #1;
    chk("abort_pointer_reset", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(cyc);
    chk("post_abort_sum", {16'd0, sum}, 32'h0300);
    tick();

    // Busy rejection: req1 raised during requester 0's run
    set_req(0, 16'h4000, 16'h0123, 1'b1);
    #1;
    tick();
    req0 = 1'b0;
    tick();
    set_req(1, 16'h00F0, 16'h000F, 1'b0);
    for (int c = 2; c < 6; c++) begin
      #1;
      chk("busy_reject_gnt1", {31'd0, gnt1}, 32'd0);
      if (c == 5) chk("busy_reject_done", {31'd0, done}, 32'd1);
      tick();
    end
    #1;
    chk("gnt1_after_done", {30'd0, gnt1, gnt0}, 32'd2);
    tick();
    req1 = 1'b0;
    wait_done(cyc);
    m = model(16'h00F0, 16'h000F, 1'b0);
    chk("reject_followup_sum", {16'd0, sum}, {16'd0, m[15:0]});
    chk("reject_followup_owner", {31'd0, owner}, 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_seq_arb.md
Name: cla_seq_arb

Overview:
- Two-requester arbiter and sequencer that shares one 4-bit carry-lookahead nibble adder slice (a + b + cin) across a multi-nibble add/subtract.
- Accepts a W-bit add or subtract from one of two requesters using round-robin arbitration.
- Runs the operation one nibble per cycle, LSB first, through the shared slice, rippling carry through a register.
- Returns the sum with carry, signed-overflow and zero flags.
- Sits between the ALU-level requesters and the 4-bit CLA datapath, replacing a full-width adder where area matters.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES (default 16).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- req0  input  1  requester 0 operation request; held until gnt0.
- a0  input  W  requester 0 operand A.
- b0  input  W  requester 0 operand B.
- sub0  input  1  requester 0: 1 = A-B, 0 = A+B.
- req1  input  1  requester 1 request; held until gnt1.
- a1  input  W  requester 1 operand A.
- b1  input  W  requester 1 operand B.
- sub1  input  1  requester 1 subtract select.
- gnt0  output  1  one-cycle grant to requester 0; operands sampled at this edge.
- gnt1  output  1  one-cycle grant to requester 1.
- busy  output  1  high from the cycle after a grant through the DONE cycle.
- done  output  1  one-cycle pulse; result outputs valid.
- owner  output  1  requester index of the current or last result.
- sum  output  W  result.
- cout  output  1  carry out of the MSB nibble (subtract: 1 = no borrow).
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- zero  output  1  sum == 0.

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - gnt0, gnt1, busy, done, owner, sum, cout, ovf, zero all 0.
  - Round-robin pointer set so requester 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - gnt0/gnt1 are combinational from req0/req1 and the pointer; at most one is high.
  - If only one req is high, that requester is granted.
  - If both are high, the requester not served last is granted.
  - On the grant edge:
    - Latch A; latch B inverted if sub, else B.
    - Carry register = sub.
    - Nibble index = 0; owner = granted index; pointer updated.
    - Next state RUN.
  - No req: stay in IDLE.
- RUN, one nibble per cycle (index i = 0..NIBBLES-1):
  - Slice computes A[4i+3:4i] + B'[4i+3:4i] + carry.
  - The 4-bit result is written to sum[4i+3:4i]; the carry register updates.
  - When i = NIBBLES-1, also capture carry-in to bit W-1 and the final carry-out.
  - After the last nibble, go to DONE.
- DONE (one cycle):
  - done=1 and busy=1; cout, ovf and zero updated.
  - Next state IDLE.
- Result hold:
  - sum, cout, ovf, zero and owner hold until overwritten by the next operation.
  - sum is partially updated during RUN; it is valid only when done=1 and afterwards, until the next grant.
- Latency and throughput:
  - Grant in cycle 0; done in cycle NIBBLES+1 (cycle 5 by default).
  - Earliest next grant is cycle NIBBLES+2; one operation per NIBBLES+2 cycles.
- Requests while busy: ignored, no grant, no queuing. A req dropped before its grant has no effect.
- Width rules:
  - Arithmetic is modulo 2^W; cout is bit W of A + B' + cin.
  - Subtract uses B' = ~B, cin = 1.
- Reset mid-operation: the operation is aborted, no done pulse, all outputs cleared as at reset, pointer reset.
- Simultaneous rst and req: rst wins; no grant.

Test Plan:
- Add, requester 0 only: req0, a0=0x1234, b0=0x0FFF, sub0=0.
  -> gnt0 in cycle 0, done in cycle 5, sum=0x2233, cout=0, ovf=0, zero=0, owner=0.
- Signed overflow and carry chain:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0.
- Subtract:
  - 0x0005-0x0005 -> 0x0000, zero=1, cout=1, ovf=0.
  - 0x0000-0x0001 -> 0xFFFF, cout=0, ovf=0.
  - 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
- Contention: req0 and req1 held continuously with distinct operands.
  -> Grants alternate 0,1,0,1 at cycles 0, 6, 12, 18.
  -> owner matches on each done; each result is correct for its own requester.
- Reset mid-RUN: assert rst for one cycle during nibble index 2.
  -> Next cycle busy=0, sum=0, flags=0, and done never pulses for that operation.
  -> Then with req0 and req1 both high, gnt0 is asserted first.
- Busy rejection: raise req1 during requester 0's RUN.
  -> gnt1=0 until IDLE; gnt1 is asserted the cycle after requester 0's done pulse.
